mu0_regbank: RTL

//   Parametrised general-purpose register bank for the extended MU0 datapath: NREGS words of

---
 rtl/mu0_regbank_pkg.sv | 8 +
 rtl/mu0_regen_w.sv | 18 +
 rtl/mu0_regbank.sv | 116 +++++++++++
 3 files changed

// File: rtl/mu0_regbank_pkg.sv
// mu0_regbank_pkg: shared sizing constants for the MU0 register bank and its users
package mu0_regbank_pkg;

    localparam int MU0_WIDTH = 12;
    localparam int MU0_NREGS = 4;
    localparam int MU0_AW    = $clog2(MU0_NREGS);

endpackage

// File: rtl/mu0_regen_w.sv
// mu0_regen_w: WIDTH-bit enable register with synchronous active-high reset
module mu0_regen_w #(
    parameter int WIDTH = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // load d when enabled, clear on reset
    always_ff @(posedge Clk) begin
        if (Reset) q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mu0_regbank.sv
// mu0_regbank: MU0 register bank with pending scoreboard and one-deep shadow; MU0_REGBANK_BYPASS_EN enables write-to-read forwarding
module mu0_regbank
    import mu0_regbank_pkg::*;
#(
    parameter int  WIDTH = MU0_WIDTH,
    parameter int  NREGS = MU0_NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             WrEn,
    input  logic [AW-1:0]    WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic [AW-1:0]    RdAddrA,
    output logic [WIDTH-1:0] RdDataA,
    output logic             RdValidA,
    input  logic [AW-1:0]    RdAddrB,
    output logic [WIDTH-1:0] RdDataB,
    output logic             RdValidB,
    input  logic             ResvEn,
    input  logic [AW-1:0]    ResvAddr,
    output logic             ResvAck,
    input  logic             SaveEn,
    input  logic             RestoreEn,
    output logic [NREGS-1:0] PendMask
);

    logic [WIDTH-1:0] bank   [NREGS];
    logic [WIDTH-1:0] shadow [NREGS];
    logic [NREGS-1:0] pend, shadow_pend, pend_nxt, wr_hit, resv_hit;

    // per-register write and reserve decode; out-of-range indices match nothing, restore blocks both
    always_comb begin
        wr_hit   = '0;
        resv_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_hit[i]   = WrEn && !RestoreEn && WrAddr == AW'(i);
            resv_hit[i] = ResvEn && !RestoreEn && ResvAddr == AW'(i) &&
                          (!pend[i] || (WrEn && WrAddr == ResvAddr));
        end
    end

    assign ResvAck  = |resv_hit;
    assign PendMask = pend;

    for (genvar g = 0; g < NREGS; g++) begin : g_regs
        mu0_regen_w #(.WIDTH(WIDTH)) u_bank (
            .Clk   (Clk),
            .Reset (Reset),
            .en    (RestoreEn || wr_hit[g]),
            .d     (RestoreEn ? shadow[g] : WrData),
            .q     (bank[g])
        );
        mu0_regen_w #(.WIDTH(WIDTH)) u_shadow (
            .Clk   (Clk),
            .Reset (Reset),
            .en    (SaveEn),
            .d     (bank[g]),
            .q     (shadow[g])
        );
    end

    // next pending vector: restore reloads it, otherwise reserve beats a same-index write
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < NREGS; i++)
            pend_nxt[i] = resv_hit[i] ? 1'b1 : wr_hit[i] ? 1'b0 : pend[i];
        if (RestoreEn) pend_nxt = shadow_pend;
    end

    // pending scoreboard and its shadow copy
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend        <= '0;
            shadow_pend <= '0;
        end else begin
            pend <= pend_nxt;
            if (SaveEn) shadow_pend <= pend;
        end
    end

    // read port A: stored value, optionally forwarded from the write port
    always_comb begin
        RdDataA  = '0;
        RdValidA = 1'b0;
        for (int i = 0; i < NREGS; i++)
            if (RdAddrA == AW'(i)) begin
                RdDataA  = bank[i];
                RdValidA = !pend[i];
            end
`ifdef MU0_REGBANK_BYPASS_EN
        if (|wr_hit && WrAddr == RdAddrA) begin
            RdDataA  = WrData;
            RdValidA = 1'b1;
        end
`endif
    end

    // read port B: stored value, optionally forwarded from the write port
    always_comb begin
        RdDataB  = '0;
        RdValidB = 1'b0;
        for (int i = 0; i < NREGS; i++)
            if (RdAddrB == AW'(i)) begin
                RdDataB  = bank[i];
                RdValidB = !pend[i];
            end
`ifdef MU0_REGBANK_BYPASS_EN
        if (|wr_hit && WrAddr == RdAddrB) begin
            RdDataB  = WrData;
            RdValidB = 1'b1;
        end
`endif
    end

endmodule
